// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared encodings for the fetch stage and the two-word predicate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [1:0]  CLS_IMM = 2'b00;
    localparam logic [1:0]  CLS_REG = 2'b01;
    localparam logic [1:0]  CLS_MEM = 2'b10;
    localparam logic [1:0]  CLS_LIT = 2'b11;

    localparam logic [4:0]  OP_LRLI = 5'b00010;
    localparam logic [4:0]  OP_CALL = 5'b01110;

    localparam logic [15:0] NOP     = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXT   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : ROM, decode handshake and redirect signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               fetch_en;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_word;
    logic [INSTR_W-1:0] inst_ext;
    logic               inst_two_word;
    logic [PC_W-1:0]    inst_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        input  fetch_en, rom_data, inst_ready, redirect_valid, redirect_pc,
        output rom_addr, inst_valid, inst_word, inst_ext, inst_two_word, inst_pc
    );

    modport slave (
        output fetch_en, rom_data, inst_ready, redirect_valid, redirect_pc,
        input  rom_addr, inst_valid, inst_word, inst_ext, inst_two_word, inst_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_ext_detect.sv
// ============================================================================
// Module      : fetch_ext_detect
// Description : Flags opcode words that carry a following extension word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ext_detect
    import fetch_pkg::*;
(
    input  wire logic [15:0] i_word,
    output logic             o_is_two_word
);
    logic w_is_mem;
    logic w_op_match;

    assign w_is_mem      = (i_word[15:14] == CLS_MEM);
    assign w_op_match    = (i_word[13:9] == OP_LRLI) || (i_word[13:9] == OP_CALL);
    assign o_is_two_word = w_is_mem && w_op_match;
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC owner, instruction register and two-word assembler feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fetch_unit_if.master fu_bus
);
    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_inst_valid;
    logic [INSTR_W-1:0] r_inst_word;
    logic [INSTR_W-1:0] r_inst_ext;
    logic               r_inst_two_word;
    logic [PC_W-1:0]    r_inst_pc;

    logic               w_is_two_word;
    logic               w_take;

    fetch_ext_detect u_ext_detect (
        .i_word        (fu_bus.rom_data),
        .o_is_two_word (w_is_two_word)
    );

    // A new opcode word is captured from an empty slot or when the offered one is consumed.
    assign w_take = fu_bus.fetch_en &&
                    ((r_state == ST_FETCH) ||
                     ((r_state == ST_VALID) && fu_bus.inst_ready));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_FETCH;
            r_pc            <= RESET_PC;
            r_inst_valid    <= 1'b0;
            r_inst_word     <= NOP;
            r_inst_ext      <= '0;
            r_inst_two_word <= 1'b0;
            r_inst_pc       <= '0;
        end else if (fu_bus.redirect_valid) begin
            r_state      <= ST_FETCH;
            r_pc         <= fu_bus.redirect_pc;
            r_inst_valid <= 1'b0;
        end else if (w_take) begin
            r_inst_word     <= fu_bus.rom_data;
            r_inst_pc       <= r_pc;
            r_pc            <= r_pc + c_PC_ONE;
            r_inst_ext      <= '0;
            r_inst_two_word <= w_is_two_word;
            r_inst_valid    <= !w_is_two_word;
            r_state         <= w_is_two_word ? ST_EXT : ST_VALID;
        end else begin
            case (r_state)
                ST_EXT: begin
                    r_inst_ext   <= fu_bus.rom_data;
                    r_pc         <= r_pc + c_PC_ONE;
                    r_inst_valid <= 1'b1;
                    r_state      <= ST_VALID;
                end
                ST_VALID: begin
                    if (fu_bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_inst_valid <= 1'b0;
                    r_state      <= ST_FETCH;
                end
            endcase
        end
    end

    assign fu_bus.rom_addr      = r_pc;
    assign fu_bus.inst_valid    = r_inst_valid;
    assign fu_bus.inst_word     = r_inst_word;
    assign fu_bus.inst_ext      = r_inst_ext;
    assign fu_bus.inst_two_word = r_inst_two_word;
    assign fu_bus.inst_pc       = r_inst_pc;
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed vector table plus randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    typedef struct {
        bit          rn;
        bit          fe;
        bit          rdy;
        bit          rv;
        logic [7:0]  rpc;
        bit          ev;
        logic [15:0] ew;
        logic [15:0] ee;
        bit          et;
        logic [7:0]  ep;
        logic [7:0]  ea;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom [256];
    vec_t        vq [$];
    int          n_cmp;
    int          n_bad;

    fetch_unit_if #(.PC_W(8), .INSTR_W(16)) bus ();

    fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .fu_bus (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_two(input logic [15:0] w);
        int cls;
        int op;
        cls = int'(w) / 16384;
        op  = (int'(w) / 512) % 32;
        return (cls == 2) && (op == 2 || op == 14);
    endfunction

    task automatic add(input bit rn, fe, rdy, rv, input logic [7:0] rpc,
                       input bit ev, input logic [15:0] ew, ee, input bit et,
                       input logic [7:0] ep, ea);
        vec_t v;
        v.rn = rn; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.ew = ew; v.ee = ee; v.et = et; v.ep = ep; v.ea = ea;
        vq.push_back(v);
    endtask

    task automatic drive(input bit rn, fe, rdy, rv, input logic [7:0] rpc);
        rst_n              = rn;
        bus.fetch_en       = fe;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic check(input string tag, input int idx, input bit ev,
                         input logic [15:0] ew, ee, input bit et,
                         input logic [7:0] ep, ea, input bit chk_data);
        n_cmp++;
        if (bus.inst_valid !== ev || bus.rom_addr !== ea) begin
            n_bad++;
            $display("FAIL %s#%0d ctl: got valid=%0b rom_addr=%02h, want valid=%0b rom_addr=%02h",
                     tag, idx, bus.inst_valid, bus.rom_addr, ev, ea);
        end
        if (chk_data) begin
            n_cmp++;
            if (bus.inst_word !== ew || bus.inst_ext !== ee ||
                bus.inst_two_word !== et || bus.inst_pc !== ep) begin
                n_bad++;
                $display("FAIL %s#%0d data: got word=%04h ext=%04h two=%0b pc=%02h, want word=%04h ext=%04h two=%0b pc=%02h",
                         tag, idx, bus.inst_word, bus.inst_ext, bus.inst_two_word, bus.inst_pc,
                         ew, ee, et, ep);
            end
        end
    endtask

    initial begin
        logic [7:0]  m_pc, m_ipc, r_pc;
        logic [15:0] m_word, m_ext, w;
        bit          m_have, m_pend, m_two;
        bit          rn, fe, rdy, rv;

        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h404A; rom[8'h01] = 16'h0901; rom[8'h02] = 16'h1234;
        rom[8'h03] = 16'h2345; rom[8'h04] = 16'h3456; rom[8'h05] = 16'h4567;
        rom[8'h16] = 16'h844A; rom[8'h17] = 16'h0001; rom[8'h18] = 16'h5001;
        rom[8'h1E] = 16'h9C05; rom[8'h1F] = 16'h1111; rom[8'h20] = 16'hB301;
        rom[8'hFE] = 16'h8405; rom[8'hFF] = 16'hD801;

        //   rn fe rdy rv rpc    ev word     ext      two pc     addr
        add(0, 1, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00);
        add(1, 1, 1, 0, 8'h00, 1, 16'h404A, 16'h0000, 0, 8'h00, 8'h01);
        add(1, 1, 1, 0, 8'h00, 1, 16'h0901, 16'h0000, 0, 8'h01, 8'h02);
        add(1, 1, 1, 0, 8'h00, 1, 16'h1234, 16'h0000, 0, 8'h02, 8'h03);
        add(1, 1, 0, 0, 8'h00, 1, 16'h1234, 16'h0000, 0, 8'h02, 8'h03);
        add(1, 1, 0, 0, 8'h00, 1, 16'h1234, 16'h0000, 0, 8'h02, 8'h03);
        add(1, 1, 0, 0, 8'h00, 1, 16'h1234, 16'h0000, 0, 8'h02, 8'h03);
        add(1, 1, 1, 0, 8'h00, 1, 16'h2345, 16'h0000, 0, 8'h03, 8'h04);
        add(1, 0, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h04);
        add(1, 0, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h04);
        add(1, 1, 1, 0, 8'h00, 1, 16'h3456, 16'h0000, 0, 8'h04, 8'h05);
        add(1, 1, 1, 1, 8'h16, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h16);
        add(1, 1, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h17);
        add(1, 1, 1, 0, 8'h00, 1, 16'h844A, 16'h0001, 1, 8'h16, 8'h18);
        add(1, 1, 1, 0, 8'h00, 1, 16'h5001, 16'h0000, 0, 8'h18, 8'h19);
        add(1, 1, 1, 1, 8'h1E, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h1E);
        add(1, 1, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h1F);
        add(1, 1, 1, 1, 8'h20, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h20);
        add(1, 1, 1, 0, 8'h00, 1, 16'hB301, 16'h0000, 0, 8'h20, 8'h21);
        add(1, 1, 1, 1, 8'hFF, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'hFF);
        add(1, 1, 1, 0, 8'h00, 1, 16'hD801, 16'h0000, 0, 8'hFF, 8'h00);
        add(1, 1, 1, 0, 8'h00, 1, 16'h404A, 16'h0000, 0, 8'h00, 8'h01);
        add(1, 1, 1, 1, 8'h16, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h16);
        add(1, 1, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h17);
        add(0, 1, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00);
        add(1, 1, 1, 1, 8'hFE, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'hFE);
        add(1, 1, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'hFF);
        add(1, 1, 0, 0, 8'h00, 1, 16'h8405, 16'hD801, 1, 8'hFE, 8'h00);
        add(1, 1, 1, 0, 8'h00, 1, 16'h404A, 16'h0000, 0, 8'h00, 8'h01);

        // Directed table: data fields matter when an instruction is offered or after reset.
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rn, vq[i].fe, vq[i].rdy, vq[i].rv, vq[i].rpc);
            @(posedge clk);
            #1;
            check("vec", i, vq[i].ev, vq[i].ew, vq[i].ee, vq[i].et, vq[i].ep, vq[i].ea,
                  vq[i].ev || !vq[i].rn);
        end

        // Random program with a generous share of two-word opcodes.
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0)
                rom[i] = {2'b10, ($urandom_range(0, 1) == 0) ? 5'b00010 : 5'b01110, 9'($urandom)};
            else
                rom[i] = 16'($urandom);
        end

        m_pc = 0; m_ipc = 0; m_word = 0; m_ext = 0;
        m_have = 0; m_pend = 0; m_two = 0;
        for (int c = 0; c < 3000; c++) begin
            rn  = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            fe  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            r_pc = 8'($urandom);
            drive(rn, fe, rdy, rv, r_pc);

            if (!rn) begin
                m_pc = 8'h00; m_have = 0; m_pend = 0;
                m_word = 16'h0000; m_ext = 0; m_two = 0; m_ipc = 0;
            end else if (rv) begin
                m_pc = r_pc; m_have = 0; m_pend = 0;
            end else if (m_pend) begin
                m_ext = rom[m_pc]; m_pc = m_pc + 8'd1; m_pend = 0; m_have = 1;
            end else if (fe && (!m_have || rdy)) begin
                w = rom[m_pc];
                m_word = w; m_ipc = m_pc; m_pc = m_pc + 8'd1; m_ext = 0;
                m_two  = is_two(w);
                m_pend = m_two;
                m_have = !m_two;
            end else if (m_have && rdy) begin
                m_have = 0;
            end

            @(posedge clk);
            #1;
            check("rnd", c, m_have, m_word, m_ext, m_two, m_ipc, m_pc, m_have || !rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
